// File: rtl/lutram_fifo_ctrl.sv
// rtl/lutram_fifo_ctrl.sv - first-word-fall-through FIFO control around a ReadFirst dual-port LUTRAM
module lutram_fifo_ctrl #(
    parameter int BYTE_LEN_IN_BITS           = 8,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_SET                    = 64,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,

    input  logic                                  request_valid_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    output logic                                  request_ack_out,

    output logic                                  issue_valid_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] issue_out,
    input  logic                                  issue_ack_in,

    output logic                                  write_port_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             write_port_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      write_port_access_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_port_data_out,

    output logic                                  read_port_access_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      read_port_access_set_addr_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_in,

    output logic                                  fifo_full_out,
    output logic                                  fifo_empty_out
);

    localparam int CW = SET_PTR_WIDTH_IN_BITS + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_SET);

    logic [SET_PTR_WIDTH_IN_BITS-1:0]      wr_ptr;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]      rd_ptr;
    logic [CW-1:0]                         ram_count;
    logic                                  inflight;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] out_buf [2];
    logic                                  head;
    logic [1:0]                            buf_count;

    logic       full;
    logic       enq;
    logic       deq;
    logic       rd_issue;
    logic       tail;
    logic [2:0] pending;

    // Full looks only at registered RAM occupancy, so a same-cycle read never
    // frees the slot being written and the two ports never share an address.
    assign full            = (ram_count == FULL_COUNT);
    assign request_ack_out = ~reset_in & ~full;
    assign enq             = request_valid_in & request_ack_out;

    assign issue_valid_out = (buf_count != 2'd0);
    assign issue_out       = issue_valid_out ? out_buf[head] : '0;
    assign deq             = issue_valid_out & issue_ack_in;

    // Entries already committed to the output buffer (held or on their way
    // back from the LUTRAM); a new read is issued only if it will have a slot.
    assign pending  = {1'b0, buf_count} + {2'b00, inflight};
    assign rd_issue = (ram_count != '0) & (pending < (3'd2 + {2'b00, deq}));

    // With one entry buffered the free slot is the one after head; a capture
    // never coincides with a full buffer, so bit 0 of buf_count suffices.
    assign tail = head ^ buf_count[0];

    assign write_port_access_en_out       = enq;
    assign write_port_write_en_out        = {WRITE_MASK_LEN{enq}};
    assign write_port_access_set_addr_out = wr_ptr;
    assign write_port_data_out            = request_in;

    assign read_port_access_en_out       = rd_issue;
    assign read_port_access_set_addr_out = rd_ptr;

    assign fifo_full_out  = full;
    assign fifo_empty_out = (ram_count == '0) & ~inflight & (buf_count == 2'd0);

    // RAM pointers, occupancy and the outstanding-read flag.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_count <= ram_count + CW'(enq) - CW'(rd_issue);
            inflight  <= rd_issue;
        end
    end

    // Output buffer bookkeeping: head advances on dequeue, count tracks capture vs dequeue.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            head      <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (deq) begin
                head <= ~head;
            end
            case ({inflight, deq})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Returning LUTRAM data lands at the buffer tail; reset clears inflight so
    // a read outstanding across reset is never captured.
    always_ff @(posedge clk_in) begin
        if (inflight) begin
            out_buf[tail] <= read_port_data_in;
        end
    end

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// tb/tb_lutram_fifo_ctrl.sv - scoreboard bench for lutram_fifo_ctrl with a behavioural ReadFirst LUTRAM
module tb_lutram_fifo_ctrl;

    localparam int W  = 32;
    localparam int NS = 4;
    localparam int PW = 2;
    localparam int WM = W / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [W-1:0]  req;
    logic          req_ack;
    logic          iss_valid;
    logic [W-1:0]  iss_out;
    logic          iss_ack;
    logic          wr_en;
    logic [WM-1:0] wr_mask;
    logic [PW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [PW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          full;
    logic          empty;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] sb [$];
    logic [W-1:0] mem [NS];

    always #5 clk = ~clk;

    lutram_fifo_ctrl #(
        .BYTE_LEN_IN_BITS          (8),
        .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .NUM_SET                   (NS),
        .SET_PTR_WIDTH_IN_BITS     (PW),
        .WRITE_MASK_LEN            (WM)
    ) dut (
        .clk_in                        (clk),
        .reset_in                      (rst),
        .request_valid_in              (req_valid),
        .request_in                    (req),
        .request_ack_out               (req_ack),
        .issue_valid_out               (iss_valid),
        .issue_out                     (iss_out),
        .issue_ack_in                  (iss_ack),
        .write_port_access_en_out      (wr_en),
        .write_port_write_en_out       (wr_mask),
        .write_port_access_set_addr_out(wr_addr),
        .write_port_data_out           (wr_data),
        .read_port_access_en_out       (rd_en),
        .read_port_access_set_addr_out (rd_addr),
        .read_port_data_in             (rd_data),
        .fifo_full_out                 (full),
        .fifo_empty_out                (empty)
    );

    // ReadFirst LUTRAM: registered read, zero when not enabled, byte-masked write.
    always @(posedge clk) begin
        for (int b = 0; b < WM; b++) begin
            if (wr_en && wr_mask[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
        rd_data <= rd_en ? mem[rd_addr] : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req = 32'h55; iss_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_ack !== 1'b0 || iss_valid !== 1'b0 || iss_out !== '0 || full !== 1'b0 ||
            empty !== 1'b1 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b ivalid=%b iout=%h full=%b empty=%b wen=%b ren=%b want 0 0 0 0 1 0 0",
                     req_ack, iss_valid, iss_out, full, empty, wr_en, rd_en);
        end
        tick();
        rst = 1'b0; req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (empty !== 1'b1 || req_ack !== 1'b1 || iss_valid !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_c%0d: empty=%b ack=%b ivalid=%b wen=%b ren=%b want 1 1 0 0 0",
                         c, empty, req_ack, iss_valid, wr_en, rd_en);
            end
            tick();
        end
    endtask

    task automatic test_single();
        req_valid = 1'b1; req = 32'hA5A5; iss_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ack !== 1'b1) begin
            miscompares++; $display("FAIL single_ack: got %b want 1", req_ack);
        end
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vectors++;
            if (c < 3 && iss_valid !== 1'b0) begin
                miscompares++; $display("FAIL single_early_c%0d: ivalid=%b want 0", c, iss_valid);
            end else if (c >= 3 && (iss_valid !== 1'b1 || iss_out !== 32'hA5A5)) begin
                miscompares++; $display("FAIL single_c%0d: ivalid=%b iout=%h want 1 a5a5", c, iss_valid, iss_out);
            end
            tick();
        end
        iss_ack = 1'b1;
        @(negedge clk);
        tick();
        iss_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (empty !== 1'b1 || iss_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_drain: empty=%b ivalid=%b want 1 0", empty, iss_valid);
        end
        tick();
    endtask

    task automatic test_fill();
        int acc = 0;
        int drained = 0;
        logic [W-1:0] exp;
        sb.delete();
        iss_ack = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req = W'(acc + 1);
            @(negedge clk);
            if (req_ack) begin sb.push_back(req); acc++; end
            tick();
        end
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (acc != 6 || req_ack !== 1'b0 || full !== 1'b1 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_capacity: accepted=%0d ack=%b full=%b empty=%b want 6 0 1 0", acc, req_ack, full, empty);
        end
        tick();
        iss_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (empty) break;
            if (iss_valid) begin
                vectors++;
                exp = (sb.size() != 0) ? sb.pop_front() : '1;
                if (iss_out !== exp) begin
                    miscompares++; $display("FAIL fill_order: got %h want %h", iss_out, exp);
                end
                drained++;
            end
            tick();
        end
        iss_ack = 1'b0;
        vectors++;
        if (drained != 6 || empty !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL fill_drain: drained=%0d empty=%b left=%0d want 6 1 0", drained, empty, sb.size());
        end
        tick();
    endtask

    task automatic test_streaming();
        int sent = 0, got = 0, cyc = 0, bram = 0, maxram = 0, first = -1, last = -1;
        logic [W-1:0] exp;
        sb.delete();
        while (got < 100 && cyc < 400) begin
            req_valid = (sent < 100); req = W'(32'h100 + sent); iss_ack = 1'b1;
            @(negedge clk);
            bram = bram + int'(wr_en) - int'(rd_en);
            if (bram > maxram) maxram = bram;
            if (req_valid && req_ack) begin sb.push_back(req); sent++; end
            if (iss_valid) begin
                vectors++;
                exp = (sb.size() != 0) ? sb.pop_front() : '1;
                if (iss_out !== exp) begin
                    miscompares++; $display("FAIL stream_order: got %h want %h", iss_out, exp);
                end
                got++;
                if (got == 1) first = cyc;
                if (got == 100) last = cyc;
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0; iss_ack = 1'b0;
        vectors++;
        if (first != 3 || last != 102 || maxram != 1) begin
            miscompares++;
            $display("FAIL stream_timing: first=%0d last=%0d max_ram=%0d want 3 102 1", first, last, maxram);
        end
    endtask

    task automatic test_random();
        int sent = 0, got = 0, cyc = 0;
        logic [W-1:0] exp;
        sb.delete();
        while (got < 2000 && cyc < 30000) begin
            req_valid = (sent < 2000) && ($urandom_range(0, 1) == 1);
            req = $urandom();
            iss_ack = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (wr_en && rd_en) begin
                vectors++;
                if (wr_addr == rd_addr) begin
                    miscompares++; $display("FAIL rand_collision: wr_addr=%0d rd_addr=%0d want different", wr_addr, rd_addr);
                end
            end
            if (req_valid && req_ack) begin sb.push_back(req); sent++; end
            if (iss_valid && iss_ack) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL rand_extra: got %h want nothing", iss_out);
                end else begin
                    exp = sb.pop_front();
                    if (iss_out !== exp) begin
                        miscompares++; $display("FAIL rand_data: got %h want %h", iss_out, exp);
                    end
                end
                got++;
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0; iss_ack = 1'b0;
        vectors++;
        if (got != 2000 || sb.size() != 0) begin
            miscompares++; $display("FAIL rand_count: got=%0d left=%0d want 2000 0", got, sb.size());
        end
    endtask

    task automatic test_reset_inflight();
        sb.delete();
        iss_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1; req = W'(32'hC0 + c);
            @(negedge clk);
            tick();
        end
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (iss_valid !== 1'b1 || iss_out !== 32'hC0 || empty !== 1'b0) begin
            miscompares++; $display("FAIL rstif_pre: ivalid=%b iout=%h empty=%b want 1 c0 0", iss_valid, iss_out, empty);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (empty !== 1'b1 || iss_valid !== 1'b0 || iss_out !== '0 || req_ack !== 1'b0 || rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rstif_during: empty=%b ivalid=%b iout=%h ack=%b ren=%b want 1 0 0 0 0",
                     empty, iss_valid, iss_out, req_ack, rd_en);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (iss_valid !== 1'b0 || empty !== 1'b1) begin
                miscompares++; $display("FAIL rstif_idle_c%0d: ivalid=%b empty=%b want 0 1", c, iss_valid, empty);
            end
            tick();
        end
        req_valid = 1'b1; req = 32'h1234;
        @(negedge clk);
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            vectors++;
            if (c < 3 && iss_valid !== 1'b0) begin
                miscompares++; $display("FAIL rstif_early_c%0d: ivalid=%b want 0", c, iss_valid);
            end else if (c == 3 && (iss_valid !== 1'b1 || iss_out !== 32'h1234)) begin
                miscompares++; $display("FAIL rstif_new: ivalid=%b iout=%h want 1 1234", iss_valid, iss_out);
            end
            if (c == 3) iss_ack = 1'b1;
            tick();
        end
        iss_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++; $display("FAIL rstif_drain: empty=%b want 1", empty);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req = '0; iss_ack = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_random();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
